// File: rtl/mod_instruction_fetch_pkg.sv
// Shared CPU definitions: word width, reset/NOP constants and opcode field position.
// Imported by the fetch stage, and by the decoder for the opcode helper.
package cpu_defs;

    localparam int          WORD_W       = 32;
    localparam logic [31:0] DEF_NOP_WORD = 32'd0;
    localparam logic [31:0] DEF_RESET_PC = 32'd0;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/mod_instruction_fetch_pc.sv
// Program counter: async reset, load beats hold beats increment.
// New value visible one clock after the request; hold freezes it indefinitely.
module mod_program_counter
    import cpu_defs::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_value,
    input  logic              hold,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus1
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;

    // Modulo-2^32 increment; the all-ones address wraps to zero silently.
    assign pc_plus1 = pc_q + 32'd1;
    assign pc       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_value;
        end else if (!hold) begin
            pc_d = pc_plus1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/mod_instruction_fetch.sv
// Fetch stage: drives the ROM address from the PC and latches the word into IF/ID.
// One clock from PC to IF/ID; stall holds everything, redirect squashes the slot.
module mod_instruction_fetch
    import cpu_defs::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [WORD_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    output logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] if_id_instruction,
    output logic [WORD_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic [WORD_W-1:0] fetch_count
);

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus1;

    logic [WORD_W-1:0] if_id_instruction_q, if_id_instruction_d;
    logic [WORD_W-1:0] if_id_pc_plus1_q,    if_id_pc_plus1_d;
    logic              if_id_valid_q,       if_id_valid_d;
    logic [WORD_W-1:0] fetch_count_q,       fetch_count_d;

    mod_program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (redirect_valid),
        .load_value (redirect_target),
        .hold       (stall),
        .pc         (pc),
        .pc_plus1   (pc_plus1)
    );

    // Address comes straight from the PC flop, never from stall/redirect.
    assign address = pc;

    // A redirect leaves if_id_pc_plus1 as it was: the slot is invalid anyway.
    always_comb begin
        if_id_instruction_d = if_id_instruction_q;
        if_id_pc_plus1_d    = if_id_pc_plus1_q;
        if_id_valid_d       = if_id_valid_q;
        fetch_count_d       = fetch_count_q;
        if (redirect_valid) begin
            if_id_instruction_d = NOP_WORD;
            if_id_valid_d       = 1'b0;
        end else if (!stall) begin
            if_id_instruction_d = instruction;
            if_id_pc_plus1_d    = pc_plus1;
            if_id_valid_d       = 1'b1;
            fetch_count_d       = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_instruction_q <= NOP_WORD;
            if_id_pc_plus1_q    <= '0;
            if_id_valid_q       <= 1'b0;
            fetch_count_q       <= '0;
        end else begin
            if_id_instruction_q <= if_id_instruction_d;
            if_id_pc_plus1_q    <= if_id_pc_plus1_d;
            if_id_valid_q       <= if_id_valid_d;
            fetch_count_q       <= fetch_count_d;
        end
    end

    assign if_id_instruction = if_id_instruction_q;
    assign if_id_pc_plus1    = if_id_pc_plus1_q;
    assign if_id_valid       = if_id_valid_q;
    assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_mod_instruction_fetch.sv
// Bench for the fetch stage: directed scenarios plus random stall/redirect traffic,
// checked every cycle against a transaction-level model of the PC and IF/ID slot.
module tb_mod_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h00221820;
            32'd1:   return 32'h0485FFFF;
            32'd2:   return 32'h08000020;
            default: return 32'h00000000;
        endcase
    endfunction

    assign instruction = rom(address);

    mod_instruction_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .address           (address),
        .instruction       (instruction),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus1    (if_id_pc_plus1),
        .if_id_valid       (if_id_valid),
        .fetch_count       (fetch_count)
    );

    // Reference model: what each edge must do, by priority redirect > stall > advance.
    logic [31:0] m_pc, m_ins, m_pp1, m_cnt;
    logic        m_vld;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'd0; m_ins = 32'd0; m_pp1 = 32'd0; m_vld = 1'b0; m_cnt = 32'd0;
        end else if (redirect_valid) begin
            m_pc = redirect_target; m_ins = 32'd0; m_vld = 1'b0;
        end else if (!stall) begin
            m_ins = rom(m_pc);
            m_pp1 = m_pc + 32'd1;
            m_pc  = m_pp1;
            m_vld = 1'b1;
            m_cnt = m_cnt + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cyc_address", address, m_pc);
        chk("cyc_instr", if_id_instruction, m_ins);
        chk("cyc_pc_plus1", if_id_pc_plus1, m_pp1);
        chk("cyc_valid", {31'd0, if_id_valid}, {31'd0, m_vld});
        chk("cyc_count", fetch_count, m_cnt);
    end

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic [31:0] a, input logic [31:0] ins,
                       input logic [31:0] pp1, input logic v, input logic [31:0] cnt);
        chk({tag, "_address"}, address, a);
        chk({tag, "_instr"}, if_id_instruction, ins);
        chk({tag, "_pc_plus1"}, if_id_pc_plus1, pp1);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, v});
        chk({tag, "_count"}, fetch_count, cnt);
    endtask

    logic [31:0] seq_ins [4];

    initial begin
        seq_ins[0] = 32'h00221820;
        seq_ins[1] = 32'h0485FFFF;
        seq_ins[2] = 32'h08000020;
        seq_ins[3] = 32'h00000000;

        #2;
        lit("reset", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        #10 reset = 1'b0;

        // Straight-line fetch from address 0.
        for (int k = 0; k < 4; k++) begin
            edge_step();
            lit("seq", k + 1, seq_ins[k], k + 1, 1'b1, k + 1);
        end

        // Get pc to 2 with a valid 0485FFFF/2 in IF/ID, then stall two cycles.
        redirect_valid = 1'b1; redirect_target = 32'd1;
        edge_step();
        lit("redir1", 32'd1, 32'd0, 32'd4, 1'b0, 32'd4);
        redirect_valid = 1'b0;
        edge_step();
        lit("adv2", 32'd2, 32'h0485FFFF, 32'd2, 1'b1, 32'd5);
        stall = 1'b1;
        edge_step();
        lit("stall_a", 32'd2, 32'h0485FFFF, 32'd2, 1'b1, 32'd5);
        edge_step();
        lit("stall_b", 32'd2, 32'h0485FFFF, 32'd2, 1'b1, 32'd5);
        stall = 1'b0;
        edge_step();
        lit("unstall", 32'd3, 32'h08000020, 32'd3, 1'b1, 32'd6);

        // Redirect to 0 from pc=3: bubble, then 00221820/1.
        redirect_valid = 1'b1; redirect_target = 32'd0;
        edge_step();
        lit("redir0", 32'd0, 32'd0, 32'd3, 1'b0, 32'd6);
        redirect_valid = 1'b0;
        edge_step();
        lit("after_redir0", 32'd1, 32'h00221820, 32'd1, 1'b1, 32'd7);

        // Redirect together with stall: redirect wins; stall alone keeps the bubble.
        redirect_valid = 1'b1; stall = 1'b1; redirect_target = 32'd2;
        edge_step();
        lit("redir_stall", 32'd2, 32'd0, 32'd1, 1'b0, 32'd7);
        redirect_valid = 1'b0;
        edge_step();
        lit("stall_bubble", 32'd2, 32'd0, 32'd1, 1'b0, 32'd7);
        stall = 1'b0;

        // Wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFF;
        edge_step();
        lit("redir_top", 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0, 32'd7);
        redirect_valid = 1'b0;
        edge_step();
        lit("wrap", 32'd0, 32'd0, 32'd0, 1'b1, 32'd8);
        edge_step();
        lit("post_wrap", 32'd1, 32'h00221820, 32'd1, 1'b1, 32'd9);

        // Random traffic, including back-to-back redirects and redirect-to-self.
        for (int i = 0; i < 400; i++) begin
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_target = address;
                1:       redirect_target = 32'hFFFFFFFE + $urandom_range(0, 1);
                default: redirect_target = $urandom_range(0, 5);
            endcase
            edge_step();
        end

        // Asynchronous reset in the middle of a stalled cycle.
        stall = 1'b1; redirect_valid = 1'b0;
        redirect_target = 32'd2; redirect_valid = 1'b1;
        edge_step();
        redirect_valid = 1'b0;
        edge_step();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        lit("async_rst", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        edge_step();
        lit("post_rst", 32'd1, 32'h00221820, 32'd1, 1'b1, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_instruction_fetch.md
Name: mod_instruction_fetch

Overview:
- Fetch stage directly upstream of the combinational instruction ROM.
- Owns the program counter and drives the word address into the ROM.
- Captures the returned instruction into the IF/ID pipeline register for the decoder.
- Handles decode-stage stalls, branch/jump redirects, and a retired-fetch counter.

Parameters:
- RESET_PC, 32'd0: word address loaded into the PC on reset.
- NOP_WORD, 32'd0: instruction word placed in IF/ID when the slot is squashed or after reset.

Ports:
- clk  input  1: rising-edge clock.
- reset  input  1: asynchronous, active-high reset.
- stall  input  1: hold the PC and IF/ID contents this cycle (hazard from decode).
- redirect_valid  input  1: taken branch or jump resolved downstream.
- redirect_target  input  32: word address of the new fetch target.
- address  output  32: word address to the instruction ROM (equal to the PC register).
- instruction  input  32: word returned combinationally by the ROM for `address`.
- if_id_instruction  output  32: registered instruction for decode.
- if_id_pc_plus1  output  32: registered PC+1 of that instruction, used as the branch base.
- if_id_valid  output  1: IF/ID slot holds a real instruction.
- fetch_count  output  32: count of instructions accepted into IF/ID.

Behaviour:
- Reset (async assert, any time, including mid-stall or mid-redirect):
  - pc = RESET_PC, so address = RESET_PC immediately.
  - if_id_instruction = NOP_WORD, if_id_pc_plus1 = 0, if_id_valid = 0, fetch_count = 0.
- The ROM is combinational. `instruction` is valid in the same cycle as `address`; fetch latency is one clock from PC value to IF/ID.
- Per rising edge, priority is redirect > stall > advance.
  - Redirect (redirect_valid=1, regardless of stall):
    - pc <= redirect_target.
    - if_id_instruction <= NOP_WORD, if_id_valid <= 0 (squashes the wrong-path word).
    - fetch_count unchanged.
  - Stall (stall=1, redirect_valid=0):
    - pc, all IF/ID outputs and fetch_count hold their values.
  - Advance (stall=0, redirect_valid=0):
    - pc <= pc+1.
    - if_id_instruction <= instruction, if_id_pc_plus1 <= pc+1, if_id_valid <= 1.
    - fetch_count <= fetch_count+1.
- Arithmetic:
  - pc+1 is 32-bit modulo; 32'hFFFFFFFF wraps to 0 with no flag.
  - fetch_count wraps at 2^32.
- After a redirect, the first valid IF/ID word appears on the second edge (one-cycle bubble).
- Back-to-back redirects: the last one wins and each produces a bubble.
- A redirect target equal to the current pc is legal; it re-fetches the same word.
- Unmapped addresses return 0 from the ROM. This stage does not special-case them; 0 is latched as a valid instruction.
- No combinational path from stall or redirect inputs to `address`. `address` comes only from the pc flop.

Decomposition:
- Shared package (cpu_defs):
  - WORD_W = 32.
  - NOP_WORD constant.
  - RESET_PC constant.
  - Opcode field positions [31:26], used by the decoder.
- Sub-module mod_program_counter:
  - 32-bit register with async reset, load (redirect), hold (stall) and increment.
  - Outputs pc and pc_plus1.
- The IF/ID register and fetch_count stay in the top module.

Test Plan:
- Bench ROM contents: addr0 = 32'h00221820, addr1 = 32'h0485FFFF, addr2 = 32'h08000020, other addresses = 0.
- Reset, then release, no stall: address steps 0,1,2,3. IF/ID shows 00221820/pc+1=1, then 0485FFFF/2, then 08000020/3, then 00000000/4. if_id_valid=1 from the first edge; fetch_count=4 after 4 edges.
- Stall held 2 cycles while pc=2: address stays 2, IF/ID keeps 0485FFFF/2, fetch_count frozen. On release, the next edge latches 08000020/3.
- redirect_valid=1, target=0 while pc=3: next edge gives address=0, if_id_valid=0, IF/ID=NOP. The following edge latches 00221820/1 with valid=1.
- Redirect and stall asserted together, target=2: redirect wins, address=2, valid=0. Stall alone afterwards holds valid=0 and pc=2.
- Redirect to 32'hFFFFFFFF, then advance: address reads 0 (unmapped) and latches 0 with pc_plus1=0. The next address is 0 (wrap).
- Assert reset asynchronously mid-cycle during a stall: address=0, valid=0 and fetch_count=0 immediately, without waiting for a clock edge.
